// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryption core: one inverse round per clock over a
// 128-bit state register. Round keys are looked up combinationally from an
// external key store through rk_idx/rk. Byte i of a 128-bit block lives at
// bits [127-8*i -: 8]; byte i sits at row i%4, column i/4 (column-major).
module aes_dec_iter #(
  parameter int NR      = 10,
  parameter int RKIDX_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [127:0]       din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [RKIDX_W-1:0] rk_idx,
  input  logic [127:0]       rk,
  output logic [127:0]       dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [RKIDX_W-1:0] RND_LAST  = RKIDX_W'(NR);
  localparam logic [RKIDX_W-1:0] RND_FIRST = RKIDX_W'(NR - 1);
  localparam logic [RKIDX_W-1:0] RND_ONE   = RKIDX_W'(1);
  localparam logic [RKIDX_W-1:0] RND_ZERO  = RKIDX_W'(0);

  // GF(2^8) multiply, reduction polynomial 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ x;
      end else begin
        acc = acc;
      end
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // Row r rotated right by r bytes: out(r,c) = in(r,(c-r) mod 4).
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  // Column-wise multiply by the circulant matrix {0e,0b,0d,09}.
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  state_e               fsm_q, fsm_d;
  logic [RKIDX_W-1:0]   rnd_q, rnd_d;
  logic [127:0]         st_q, st_d;
  logic [127:0]         dout_q, dout_d;
  logic [127:0]         round_s;

  // Shared round front half: InvShiftRows, InvSubBytes, AddRoundKey.
  assign round_s = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk;

  // State, round counter, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q  <= S_IDLE;
      rnd_q  <= RND_LAST;
      st_q   <= 128'h0;
      dout_q <= 128'h0;
    end else begin
      fsm_q  <= fsm_d;
      rnd_q  <= rnd_d;
      st_q   <= st_d;
      dout_q <= dout_d;
    end
  end

  // Next-state and datapath update for IDLE/RUN/DONE.
  always_comb begin
    fsm_d  = fsm_q;
    rnd_d  = rnd_q;
    st_d   = st_q;
    dout_d = dout_q;
    case (fsm_q)
      S_IDLE: begin
        if (din_valid) begin
          st_d  = din ^ rk;
          rnd_d = RND_FIRST;
          fsm_d = S_RUN;
        end else begin
          fsm_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (rnd_q == RND_ZERO) begin
          // Final round skips InvMixColumns and lands straight in dout.
          dout_d = round_s;
          fsm_d  = S_DONE;
        end else begin
          st_d  = inv_mix_columns(round_s);
          rnd_d = rnd_q - RND_ONE;
        end
      end
      S_DONE: begin
        if (dout_ready) begin
          fsm_d = S_IDLE;
          rnd_d = RND_LAST;
        end else begin
          fsm_d = S_DONE;
        end
      end
      default: begin
        fsm_d = S_IDLE;
        rnd_d = RND_LAST;
      end
    endcase
  end

  // Round-key index: initial key in IDLE, current round in RUN, parked at 0 in DONE.
  always_comb begin
    rk_idx = RND_ZERO;
    case (fsm_q)
      S_IDLE:  rk_idx = RND_LAST;
      S_RUN:   rk_idx = rnd_q;
      S_DONE:  rk_idx = RND_ZERO;
      default: rk_idx = RND_ZERO;
    endcase
  end

  assign din_ready  = (fsm_q == S_IDLE);
  assign busy       = (fsm_q == S_RUN);
  assign dout_valid = (fsm_q == S_DONE);
  assign dout       = dout_q;

endmodule

// File: tb/tb_aes_dec_iter.sv
// Directed + randomized bench for aes_dec_iter with a byte-array AES model.
module tb_aes_dec_iter;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RK10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk;
  logic         rst_n;
  logic [127:0] din;
  logic         din_valid;
  logic         din_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];
  logic [127:0] ks      [11];

  aes_dec_iter #(.NR(10), .RKIDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .rk_idx(rk_idx), .rk(rk), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy)
  );

  assign rk = (rk_idx < 4'd11) ? ks[rk_idx] : 128'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Carry-less product followed by polynomial reduction by 0x11B.
  function automatic logic [7:0] gf_mul_tb(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // Forward S-box by brute-force inverse plus affine map; inverse table by lookup.
  task automatic build_tables();
    logic [7:0] inv, s, xb, yb;
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = 8'(y);
        if (x != 0 && gf_mul_tb(xb, yb) == 8'h01) inv = yb;
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x] = s;
      isbox_t[s] = xb;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]] ^ rcon, sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        rcon = gf_mul_tb(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Straight inverse cipher on a 4x4 byte grid using the current key store.
  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] v;
    base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    v = ct ^ ks[10];
    for (int r = 9; r >= 0; r--) begin
      for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++)
          t[4*((c+rw)%4)+rw] = isbox_t[s[4*c+rw]];
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i] ^ ks[r][127-8*i -: 8];
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
          for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gf_mul_tb(base[(j-i+4)%4], s[4*c+j]);
            v[127-8*(4*c+i) -: 8] = acc;
          end
      end
    end
    return v;
  endfunction

  // Wait for IDLE, accept ct, then track round trace and latency up to DONE.
  task automatic run_block(input string tag, input logic [127:0] ct,
                           input logic [127:0] exp_pt, input bit garbage);
    int guard;
    int lat;
    int busy_n;
    bit trace_ok;
    guard = 0;
    din = ct;
    din_valid = 1'b1;
    while (din_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
    chk({tag, "_din_ready"}, din_ready, 1'b1);
    chk({tag, "_rkidx_accept"}, rk_idx, 4'd10);
    tick();
    din = {$urandom, $urandom, $urandom, $urandom};
    din_valid = garbage;
    lat = 0;
    busy_n = 0;
    trace_ok = 1'b1;
    while (dout_valid !== 1'b1 && lat < 30) begin
      if (rk_idx !== 4'(9 - lat) || busy !== 1'b1) trace_ok = 1'b0;
      if (busy === 1'b1) busy_n++;
      tick();
      if (garbage) din = {$urandom, $urandom, $urandom, $urandom};
      lat++;
    end
    din_valid = 1'b0;
    chk({tag, "_latency"}, 128'(lat), 128'd10);
    chk({tag, "_rkidx_trace"}, 128'(trace_ok), 128'd1);
    chk({tag, "_busy_cycles"}, 128'(busy_n), 128'd10);
    chk({tag, "_rkidx_done"}, rk_idx, 4'd0);
    chk({tag, "_busy_done"}, busy, 1'b0);
    chk({tag, "_dout"}, dout, exp_pt);
  endtask

  initial begin
    logic [127:0] outs [2];
    int           acc_t [2];
    int           n_acc, n_out, guard, stall;
    bit           hold_ok;
    logic [127:0] key, ct, exp_pt;

    build_tables();
    rst_n = 1'b0;
    din = 128'h0;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    load_key(KEY_C1);
    tick();
    tick();
    chk("rst_dout", dout, 128'h0);
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_din_ready", din_ready, 1'b1);
    chk("rst_rk_idx", rk_idx, 4'd10);
    rst_n = 1'b1;
    tick();

    // Model sanity against the published vectors.
    chk("ks_rk10", ks[10], RK10_C1);
    chk("model_c1", ref_decrypt(CT_C1), PT_C1);
    load_key(KEY_B);
    chk("model_b", ref_decrypt(CT_B), PT_B);

    // Known-answer decrypt with rk_idx/busy trace and latency.
    load_key(KEY_C1);
    run_block("t1", CT_C1, PT_C1, 1'b0);
    tick();

    // Back-pressure in DONE with ignored din_valid pulses.
    dout_ready = 1'b0;
    run_block("t3", CT_C1, PT_C1, 1'b0);
    hold_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      din_valid = k[0];
      din = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (dout !== PT_C1 || dout_valid !== 1'b1 || din_ready !== 1'b0 || busy !== 1'b0)
        hold_ok = 1'b0;
    end
    din_valid = 1'b0;
    chk("t3_hold", 128'(hold_ok), 128'd1);
    dout_ready = 1'b1;
    tick();
    chk("t3_release_ready", din_ready, 1'b1);
    chk("t3_release_valid", dout_valid, 1'b0);

    // Back-to-back with din_valid and dout_ready held high.
    load_key(KEY_C1);
    din = CT_C1;
    din_valid = 1'b1;
    n_acc = 0;
    n_out = 0;
    acc_t[0] = 0; acc_t[1] = 0;
    outs[0] = 'x; outs[1] = 'x;
    for (int k = 0; k < 60 && n_out < 2; k++) begin
      if (din_ready === 1'b1 && n_acc < 2) begin acc_t[n_acc] = cyc; n_acc++; end
      tick();
      if (n_acc == 1) din = CT_B;
      if (dout_valid === 1'b1 && n_out < 2) begin
        outs[n_out] = dout;
        n_out++;
        if (n_out == 1) load_key(KEY_B);
      end
    end
    din_valid = 1'b0;
    chk("t4_pt1", outs[0], PT_C1);
    chk("t4_pt2", outs[1], PT_B);
    chk("t4_interval", 128'(acc_t[1] - acc_t[0]), 128'd12);
    tick();

    // Reset in the middle of a block.
    load_key(KEY_C1);
    din = CT_C1;
    din_valid = 1'b1;
    chk("t5_ready", din_ready, 1'b1);
    tick();
    din_valid = 1'b0;
    guard = 0;
    while (rk_idx !== 4'd5 && guard < 20) begin tick(); guard++; end
    chk("t5_round5", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_dout", dout, 128'h0);
    chk("t5_dout_valid", dout_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_din_ready", din_ready, 1'b1);
    run_block("t5b", CT_C1, PT_C1, 1'b0);
    tick();

    // Garbage din_valid/din during RUN.
    run_block("t6", CT_C1, PT_C1, 1'b1);
    tick();

    // Random keys and ciphertexts against the model, with random output stalls.
    for (int n = 0; n < 5; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      exp_pt = ref_decrypt(ct);
      dout_ready = 1'b0;
      run_block($sformatf("rnd%0d", n), ct, exp_pt, 1'b0);
      stall = int'($urandom_range(0, 5));
      for (int k = 0; k < stall; k++) tick();
      chk($sformatf("rnd%0d_stall", n), dout, exp_pt);
      dout_ready = 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
